smaesh_key_sequencer: RTL and testbench



---
 rtl/smaesh_key_seq_pkg.sv | 30 +++
 rtl/smaesh_word_budget_counter.sv | 38 +++
 rtl/smaesh_key_sequencer.sv | 159 +++++++++++++++
 tb/tb_smaesh_key_sequencer.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/smaesh_key_seq_pkg.sv
// rtl/smaesh_key_seq_pkg.sv - shared key-size codes, sequencer states and word budget helper
package smaesh_key_seq_pkg;

    localparam logic [1:0] KSIZE_128     = 2'd0;
    localparam logic [1:0] KSIZE_192     = 2'd1;
    localparam logic [1:0] KSIZE_256     = 2'd2;
    localparam logic [1:0] KSIZE_ILLEGAL = 2'd3;

    localparam int MAX_WORDS_PER_SHARE = 8;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_ARM,
        ST_STREAM,
        ST_WAIT_HOLDER,
        ST_LAST_KEY_RUN,
        ST_LAST_KEY_WAIT
    } seq_state_t;

    // 32-bit words per share for a given key size code
    function automatic logic [3:0] words_per_share(input logic [1:0] ksize);
        case (ksize)
            KSIZE_128: words_per_share = 4'd4;
            KSIZE_192: words_per_share = 4'd6;
            default:   words_per_share = 4'd8;
        endcase
    endfunction

endpackage

// File: rtl/smaesh_word_budget_counter.sv
// rtl/smaesh_word_budget_counter.sv - counts streamed share words against the d*words_per_share bound
module smaesh_word_budget_counter
    import smaesh_key_seq_pkg::*;
#(
    parameter int d  = 2,
    parameter int CW = $clog2(MAX_WORDS_PER_SHARE * d + 1)
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_load,
    input  logic [1:0] i_ksize,
    input  logic       i_inc,
    output logic       o_last
);

    logic [CW-1:0] r_count;
    logic [CW-1:0] r_bound;
    logic [CW-1:0] w_bound;

    assign w_bound = CW'(d * int'(words_per_share(i_ksize)));

    // o_last flags that the word currently being offered is the final one
    assign o_last = (r_count == (r_bound - CW'(1)));

    // clear and capture the bound on load, otherwise step once per accepted word
    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= '0;
            r_bound <= '0;
        end else if (i_load) begin
            r_count <= '0;
            r_bound <= w_bound;
        end else if (i_inc) begin
            r_count <= r_count + CW'(1);
        end
    end

endmodule

// File: rtl/smaesh_key_sequencer.sv
// rtl/smaesh_key_sequencer.sv - key-config command handling, share streaming and core start gating
module smaesh_key_sequencer
    import smaesh_key_seq_pkg::*;
#(
    parameter int d = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cfg_valid,
    output logic        cfg_ready,
    input  logic [1:0]  cfg_key_size,
    input  logic        cfg_mode_inverse,
    input  logic [31:0] key_data,
    input  logic        key_valid,
    output logic        key_ready,
    output logic [31:0] kh_data_in,
    output logic        kh_data_in_valid,
    input  logic        kh_data_in_ready,
    output logic        kh_start_fetch,
    output logic [1:0]  kh_key_size_cfg,
    output logic        kh_mode_inverse,
    input  logic        kh_busy,
    input  logic        kh_last_key_req,
    input  logic        aes_busy,
    input  logic        usr_start_valid,
    output logic        usr_start_ready,
    output logic        core_start,
    output logic        key_loaded,
    output logic        cfg_err
);

    seq_state_t r_state;
    seq_state_t w_next;

    logic [1:0] r_ksize;
    logic       r_inverse;
    logic       r_key_loaded;
    logic       r_cfg_err;

    logic w_free;
    logic w_cfg_hs;
    logic w_cfg_illegal;
    logic w_word_hs;
    logic w_cnt_load;
    logic w_last_word;
    logic w_load_done;

    assign w_free        = ~kh_busy & ~aes_busy;
    assign w_cfg_hs      = (r_state == ST_IDLE) & cfg_valid & w_free;
    assign w_cfg_illegal = (cfg_key_size == KSIZE_ILLEGAL);
    assign w_word_hs     = (r_state == ST_STREAM) & key_valid & kh_data_in_ready;
    assign w_cnt_load    = (r_state == ST_ARM) & kh_busy;
    assign w_load_done   = ((r_state == ST_WAIT_HOLDER) & ~kh_busy) |
                           ((r_state == ST_LAST_KEY_WAIT) & w_free);

    assign kh_data_in      = key_data;
    assign kh_key_size_cfg = r_ksize;
    assign kh_mode_inverse = r_inverse;
    assign key_loaded      = r_key_loaded;
    assign cfg_err         = r_cfg_err;

    smaesh_word_budget_counter #(
        .d (d)
    ) u_budget (
        .clk     (clk),
        .rst     (rst),
        .i_load  (w_cnt_load),
        .i_ksize (r_ksize),
        .i_inc   (w_word_hs),
        .o_last  (w_last_word)
    );

    // state register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // latched key configuration, completion flag and sticky illegal-size error
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ksize      <= KSIZE_128;
            r_inverse    <= 1'b0;
            r_key_loaded <= 1'b0;
            r_cfg_err    <= 1'b0;
        end else begin
            if (w_cfg_hs && w_cfg_illegal) begin
                r_cfg_err <= 1'b1;
            end else if (w_cfg_hs) begin
                r_ksize      <= cfg_key_size;
                r_inverse    <= cfg_mode_inverse;
                r_key_loaded <= 1'b0;
            end
            if (w_load_done) begin
                r_key_loaded <= 1'b1;
            end
        end
    end

    // next-state and handshake outputs; a key load always beats a user core start
    always_comb begin
        w_next           = r_state;
        cfg_ready        = 1'b0;
        key_ready        = 1'b0;
        kh_data_in_valid = 1'b0;
        kh_start_fetch   = 1'b0;
        usr_start_ready  = 1'b0;
        core_start       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                cfg_ready       = w_free;
                usr_start_ready = r_key_loaded & w_free & ~cfg_valid;
                core_start      = usr_start_valid & r_key_loaded & w_free & ~cfg_valid;
                if (w_cfg_hs && !w_cfg_illegal) begin
                    w_next = ST_START;
                end
            end
            ST_START: begin
                kh_start_fetch = 1'b1;
                w_next         = ST_ARM;
            end
            ST_ARM: begin
                if (kh_busy) begin
                    w_next = ST_STREAM;
                end
            end
            ST_STREAM: begin
                key_ready        = kh_data_in_ready;
                kh_data_in_valid = key_valid;
                if (w_word_hs && w_last_word) begin
                    w_next = ST_WAIT_HOLDER;
                end
            end
            ST_WAIT_HOLDER: begin
                if (!kh_busy) begin
                    w_next = ST_IDLE;
                end else if (kh_last_key_req) begin
                    w_next = ST_LAST_KEY_RUN;
                end
            end
            ST_LAST_KEY_RUN: begin
                core_start = 1'b1;
                w_next     = ST_LAST_KEY_WAIT;
            end
            ST_LAST_KEY_WAIT: begin
                if (w_free) begin
                    w_next = ST_IDLE;
                end
            end
            default: begin
                w_next = ST_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_smaesh_key_sequencer.sv
// tb/tb_smaesh_key_sequencer.sv - randomized self-checking bench with holder/core reference model
module tb_smaesh_key_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        cfg_valid;
    logic        cfg_ready;
    logic [1:0]  cfg_key_size;
    logic        cfg_mode_inverse;
    logic [31:0] key_data;
    logic        key_valid;
    logic        key_ready;
    logic [31:0] kh_data_in;
    logic        kh_data_in_valid;
    logic        kh_data_in_ready;
    logic        kh_start_fetch;
    logic [1:0]  kh_key_size_cfg;
    logic        kh_mode_inverse;
    logic        kh_busy;
    logic        kh_last_key_req;
    logic        aes_busy;
    logic        usr_start_valid;
    logic        usr_start_ready;
    logic        core_start;
    logic        key_loaded;
    logic        cfg_err;

    int checks = 0;
    int errors = 0;
    int fetch_cnt = 0;
    int core_cnt = 0;
    logic [31:0] exp_q[$];
    logic [31:0] got_q[$];

    smaesh_key_sequencer #(.d(2)) dut (
        .clk              (clk),
        .rst              (rst),
        .cfg_valid        (cfg_valid),
        .cfg_ready        (cfg_ready),
        .cfg_key_size     (cfg_key_size),
        .cfg_mode_inverse (cfg_mode_inverse),
        .key_data         (key_data),
        .key_valid        (key_valid),
        .key_ready        (key_ready),
        .kh_data_in       (kh_data_in),
        .kh_data_in_valid (kh_data_in_valid),
        .kh_data_in_ready (kh_data_in_ready),
        .kh_start_fetch   (kh_start_fetch),
        .kh_key_size_cfg  (kh_key_size_cfg),
        .kh_mode_inverse  (kh_mode_inverse),
        .kh_busy          (kh_busy),
        .kh_last_key_req  (kh_last_key_req),
        .aes_busy         (aes_busy),
        .usr_start_valid  (usr_start_valid),
        .usr_start_ready  (usr_start_ready),
        .core_start       (core_start),
        .key_loaded       (key_loaded),
        .cfg_err          (cfg_err)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // reference: d shares, each 4/6/8 words for 128/192/256
    function automatic int n_words(input logic [1:0] ks);
        return 2 * (4 + 2 * int'(ks));
    endfunction

    // settle after driving inputs, then tally one cycle's worth of pulses and holder writes
    task automatic sample();
        #1;
        if (kh_start_fetch) fetch_cnt++;
        if (core_start) core_cnt++;
        if (kh_data_in_valid && kh_data_in_ready) got_q.push_back(kh_data_in);
    endtask

    task automatic next_cyc();
        @(negedge clk);
    endtask

    // one full key load; holder and core behaviour modelled here; ends right after a sample
    task automatic do_load(input logic [1:0] ks, input logic inv, input int bp,
                           input int abort_at, input logic hold_usr);
        int n = n_words(ks);
        int idx = 0;
        int guard = 0;
        int f0 = fetch_cnt;
        int c0 = core_cnt;
        int rdy_mis = 0;
        int cfg_unstable = 0;
        int usr_bad = 0;
        int data_mis = 0;
        logic tog = 1'b0;
        exp_q.delete();
        got_q.delete();
        for (int i = 0; i < n; i++) exp_q.push_back($urandom);

        cfg_valid = 1'b1; cfg_key_size = ks; cfg_mode_inverse = inv;
        sample();
        check("cfg_ready_idle", 32'(cfg_ready), 32'd1);
        if (hold_usr) begin
            check("usr_blocked_by_cfg", 32'(usr_start_ready), 32'd0);
            check("no_core_start_on_cfg", 32'(core_start), 32'd0);
        end
        next_cyc();
        cfg_valid = 1'b0; cfg_key_size = 2'($urandom_range(0, 2)); cfg_mode_inverse = 1'($urandom);
        sample();
        check("start_pulse", 32'(kh_start_fetch), 32'd1);
        check("key_ready_in_start", 32'(key_ready), 32'd0);
        check("key_loaded_cleared", 32'(key_loaded), 32'd0);
        next_cyc();
        kh_busy = 1'b1; key_valid = 1'b1; key_data = exp_q[0]; kh_data_in_ready = 1'b1;
        sample();
        check("key_ready_in_arm", 32'(key_ready), 32'd0);
        next_cyc();

        while (idx < n && guard < 500) begin
            if (abort_at > 0 && idx == abort_at) break;
            key_valid = ($urandom_range(0, 3) != 0);
            key_data  = exp_q[idx];
            case (bp)
                0:       kh_data_in_ready = 1'b1;
                1:       kh_data_in_ready = tog;
                default: kh_data_in_ready = 1'($urandom);
            endcase
            tog = ~tog;
            sample();
            if (key_ready !== kh_data_in_ready) rdy_mis++;
            if (kh_key_size_cfg !== ks || kh_mode_inverse !== inv) cfg_unstable++;
            if (hold_usr && usr_start_ready) usr_bad++;
            if (key_valid && key_ready) idx++;
            next_cyc();
            guard++;
        end

        if (abort_at > 0) begin
            rst = 1'b1; kh_busy = 1'b0; key_valid = 1'b0; kh_data_in_ready = 1'b0;
            sample();
            next_cyc();
            sample();
            check("rst_key_loaded", 32'(key_loaded), 32'd0);
            check("rst_cfg_err", 32'(cfg_err), 32'd0);
            check("rst_ksize", 32'(kh_key_size_cfg), 32'd0);
            check("rst_inverse", 32'(kh_mode_inverse), 32'd0);
            check("rst_key_ready", 32'(key_ready), 32'd0);
            check("rst_start_fetch", 32'(kh_start_fetch), 32'd0);
            check("rst_core_start", 32'(core_start), 32'd0);
            check("rst_usr_ready", 32'(usr_start_ready), 32'd0);
            check("rst_data_valid", 32'(kh_data_in_valid), 32'd0);
            check("abort_words", 32'(got_q.size()), 32'(abort_at));
            return;
        end

        check("words_accepted", 32'(idx), 32'(n));
        check("ready_passthrough", 32'(rdy_mis), 32'd0);
        check("cfg_latched_stable", 32'(cfg_unstable), 32'd0);
        if (hold_usr) check("usr_held_during_load", 32'(usr_bad), 32'd0);

        key_valid = 1'b1; key_data = $urandom; kh_data_in_ready = 1'b1;
        sample();
        check("extra_word_refused", 32'(key_ready), 32'd0);
        check("holder_word_count", 32'(got_q.size()), 32'(n));
        for (int i = 0; i < n && i < got_q.size(); i++)
            if (got_q[i] !== exp_q[i]) data_mis++;
        check("holder_word_order", 32'(data_mis), 32'd0);
        key_valid = 1'b0;

        if (!inv) begin
            next_cyc();
            sample();
            check("not_loaded_while_busy", 32'(key_loaded), 32'd0);
            next_cyc();
            kh_busy = 1'b0;
            sample();
            next_cyc();
            sample();
        end else begin
            next_cyc();
            kh_last_key_req = 1'b1;
            sample();
            next_cyc();
            kh_last_key_req = 1'b0;
            sample();
            check("last_key_core_start", 32'(core_start), 32'd1);
            next_cyc();
            aes_busy = 1'b1;
            sample();
            check("single_core_pulse", 32'(core_start), 32'd0);
            next_cyc();
            kh_busy = 1'b0;
            sample();
            check("wait_for_core", 32'(key_loaded), 32'd0);
            next_cyc();
            aes_busy = 1'b0;
            sample();
            next_cyc();
            sample();
        end
        check("key_loaded_set", 32'(key_loaded), 32'd1);
        check("fetch_pulses", 32'(fetch_cnt - f0), 32'd1);
        check("core_pulses", 32'(core_cnt - c0), 32'(int'(inv) + int'(hold_usr)));
        if (hold_usr) check("usr_granted_after_load", 32'(usr_start_ready), 32'd1);
    endtask

    initial begin
        logic [1:0] prev_ks;
        int f0;
        rst = 1'b1; cfg_valid = 1'b0; cfg_key_size = 2'd0; cfg_mode_inverse = 1'b0;
        key_data = '0; key_valid = 1'b0; kh_data_in_ready = 1'b0; kh_busy = 1'b0;
        kh_last_key_req = 1'b0; aes_busy = 1'b0; usr_start_valid = 1'b0;
        repeat (2) next_cyc();
        sample();
        check("reset_key_loaded", 32'(key_loaded), 32'd0);
        check("reset_cfg_err", 32'(cfg_err), 32'd0);
        check("reset_ksize", 32'(kh_key_size_cfg), 32'd0);
        check("reset_inverse", 32'(kh_mode_inverse), 32'd0);
        check("reset_start_fetch", 32'(kh_start_fetch), 32'd0);
        check("reset_usr_ready", 32'(usr_start_ready), 32'd0);
        next_cyc();
        rst = 1'b0;

        do_load(2'd0, 1'b0, 2, 0, 1'b0);
        next_cyc();
        do_load(2'd2, 1'b1, 2, 0, 1'b0);
        next_cyc();
        do_load(2'd1, 1'b0, 1, 0, 1'b0);
        next_cyc();

        usr_start_valid = 1'b1;
        do_load(2'($urandom_range(0, 2)), 1'b0, 2, 0, 1'b1);
        next_cyc();
        usr_start_valid = 1'b0;

        prev_ks = kh_key_size_cfg;
        f0 = fetch_cnt;
        cfg_valid = 1'b1; cfg_key_size = 2'd3; cfg_mode_inverse = 1'b1;
        sample();
        next_cyc();
        cfg_valid = 1'b0;
        sample();
        check("illegal_cfg_err", 32'(cfg_err), 32'd1);
        check("illegal_keeps_loaded", 32'(key_loaded), 32'd1);
        check("illegal_keeps_ksize", 32'(kh_key_size_cfg), 32'(prev_ks));
        check("illegal_stays_idle", 32'(cfg_ready), 32'd1);
        next_cyc();
        sample();
        check("illegal_no_fetch", 32'(fetch_cnt - f0), 32'd0);
        check("cfg_err_sticky", 32'(cfg_err), 32'd1);
        next_cyc();

        do_load(2'd0, 1'b1, 0, 3, 1'b0);
        next_cyc();
        rst = 1'b0;
        do_load(2'd0, 1'b0, 2, 0, 1'b0);

        for (int k = 0; k < 4; k++) begin
            next_cyc();
            do_load(2'($urandom_range(0, 2)), 1'($urandom), $urandom_range(0, 2), 0, 1'b0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
